// File: rtl/pe_traffic_gen_if.sv
// Packet bus between a PE traffic generator and its HNoC port.
// master = PE side (drives the TX packet and the RX ready),
// slave  = network side (drives TX ready and the RX packet).
interface pe_traffic_gen_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  localparam int PKT_W = DATA_W + ADDR_W;

  logic [PKT_W-1:0] o_data;
  logic             o_data_valid;
  logic             i_data_ready;
  logic [PKT_W-1:0] i_data;
  logic             i_data_valid;
  logic             o_data_ready;

  modport master (
    output o_data,
    output o_data_valid,
    input  i_data_ready,
    input  i_data,
    input  i_data_valid,
    output o_data_ready
  );

  modport slave (
    input  o_data,
    input  o_data_valid,
    output i_data_ready,
    output i_data,
    output i_data_valid,
    input  o_data_ready
  );
endinterface

// File: rtl/pe_traffic_gen.sv
// Synthetic PE endpoint for HNoC benches.
// TX: injects PKT_LIMIT packets {dest, src, seq, pad} with a selectable
// destination pattern and optional idle gap after each accept.
// RX: always ready, counts delivered packets and flags any packet whose
// destination field is not this PE.
module pe_traffic_gen #(
  parameter int ADDRESS   = 0,
  parameter int NUM_PE    = 8,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 32,
  parameter int PKT_LIMIT = 100,
  parameter int PATTERN   = 0,
  parameter int INJ_GAP   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_traffic_gen_if.master     bus,
  input  logic                 i_done,
  output logic [15:0]          o_sent_cnt,
  output logic [15:0]          o_rcvd_cnt,
  output logic                 o_tx_done,
  output logic                 o_err
);

  localparam int PKT_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] MY_ADDR   = ADDR_W'(ADDRESS);
  localparam logic [ADDR_W-1:0] NEXT_ADDR = ADDR_W'((ADDRESS + 1) % NUM_PE);
  localparam logic [15:0]       LIMIT     = 16'(PKT_LIMIT);
  localparam logic [7:0]        GAP_LAST  = 8'(INJ_GAP - 1);
  localparam logic [15:0]       LFSR_SEED = 16'(1 + ADDRESS);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} tx_state_e;

  tx_state_e        state_q, state_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [15:0]      sent_q, sent_d;
  logic [15:0]      rcvd_q, rcvd_d;
  logic             tx_done_q, tx_done_d;
  logic             err_q, err_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       gap_q, gap_d;
  logic             rx_ready_q, rx_ready_d;

  logic [ADDR_W-1:0] dest;
  logic [PKT_W-1:0]  pkt;
  logic [15:0]       sent_inc;
  logic              lfsr_fb;

  // Destination selection and packet assembly from the current LFSR and sequence number.
  always_comb begin
    dest = NEXT_ADDR;
    if (PATTERN == 0) begin
      dest = lfsr_q[ADDR_W-1:0];
      if (dest == MY_ADDR) dest = NEXT_ADDR;
    end else if (PATTERN == 1) begin
      dest = ~MY_ADDR;
    end
    pkt = '0;
    pkt[PKT_W-1 -: ADDR_W]          = dest;
    pkt[PKT_W-1-ADDR_W -: ADDR_W]   = MY_ADDR;
    pkt[PKT_W-1-2*ADDR_W -: 16]     = sent_q;
    lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
  end

  // TX FSM: LOAD builds a packet, SEND holds it until accepted, GAP throttles, DONE is terminal.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sent_d    = sent_q;
    tx_done_d = tx_done_q;
    lfsr_d    = lfsr_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (!i_done) begin
          data_d  = pkt;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.i_data_ready) begin
          sent_d  = sent_inc;
          valid_d = 1'b0;
          lfsr_d  = {lfsr_q[14:0], lfsr_fb};
          if (sent_inc == LIMIT) begin
            state_d   = DONE;
            tx_done_d = 1'b1;
          end else if (i_done) begin
            state_d = DONE;
          end else if (INJ_GAP > 0) begin
            state_d = GAP;
            gap_d   = 8'd0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        if (!i_done) begin
          if (gap_q == GAP_LAST) state_d = LOAD;
          else                   gap_d   = gap_q + 8'd1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // RX sink: never back-pressures, counts every valid beat, latches misrouted packets.
  always_comb begin
    rcvd_d     = rcvd_q;
    err_d      = err_q;
    rx_ready_d = 1'b1;
    if (bus.i_data_valid) begin
      if (rcvd_q != 16'hFFFF) rcvd_d = rcvd_q + 16'd1;
      if (bus.i_data[PKT_W-1 -: ADDR_W] != MY_ADDR) err_d = 1'b1;
    end
  end

  // State registers with synchronous reset; an in-flight packet is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sent_q     <= 16'd0;
      rcvd_q     <= 16'd0;
      tx_done_q  <= 1'b0;
      err_q      <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      gap_q      <= 8'd0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sent_q     <= sent_d;
      rcvd_q     <= rcvd_d;
      tx_done_q  <= tx_done_d;
      err_q      <= err_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_data_ready = rx_ready_q;
  assign o_sent_cnt       = sent_q;
  assign o_rcvd_cnt       = rcvd_q;
  assign o_tx_done        = tx_done_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen: three instances with different patterns/limits/gaps,
// each with its own reset so they are exercised one after another.
module tb_pe_traffic_gen;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int PKT_W  = DATA_W + ADDR_W;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
  logic [15:0] sent_a, rcvd_a, sent_b, rcvd_b, sent_c, rcvd_c;
  logic txd_a, err_a, txd_b, err_b, txd_c, err_c;

  int errors = 0;
  int checks = 0;

  pe_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
  pe_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();
  pe_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_c ();

  // Neighbour pattern, 4 packets, no gap
  pe_traffic_gen #(.ADDRESS(7), .NUM_PE(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .PKT_LIMIT(4), .PATTERN(2), .INJ_GAP(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a.master), .i_done(done_a),
    .o_sent_cnt(sent_a), .o_rcvd_cnt(rcvd_a), .o_tx_done(txd_a), .o_err(err_a));

  // Random pattern, 1000 packets
  pe_traffic_gen #(.ADDRESS(3), .NUM_PE(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .PKT_LIMIT(1000), .PATTERN(0), .INJ_GAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b.master), .i_done(done_b),
    .o_sent_cnt(sent_b), .o_rcvd_cnt(rcvd_b), .o_tx_done(txd_b), .o_err(err_b));

  // Bit-complement pattern, gap of 3
  pe_traffic_gen #(.ADDRESS(5), .NUM_PE(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .PKT_LIMIT(10), .PATTERN(1), .INJ_GAP(3)) dut_c (
    .clk(clk), .rst(rst_c), .bus(if_c.master), .i_done(done_c),
    .o_sent_cnt(sent_c), .o_rcvd_cnt(rcvd_c), .o_tx_done(txd_c), .o_err(err_c));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [15:0] seq;
    logic [15:0] sent;
    logic        done;
  } vec_t;

  vec_t vec_a [12];

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [2:0] dest, input logic [2:0] src,
                                              input logic [15:0] seq);
    mk_pkt = {dest, src, seq, 13'd0};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.i_data_ready = 1'b0; if_a.i_data_valid = 1'b0; if_a.i_data = '0;
    if_b.i_data_ready = 1'b0; if_b.i_data_valid = 1'b0; if_b.i_data = '0;
    if_c.i_data_ready = 1'b0; if_c.i_data_valid = 1'b0; if_c.i_data = '0;
  end

  initial begin
    logic [15:0] m_lfsr;
    logic [2:0]  exp_dest;
    logic [2:0]  got_dest;
    int          hist [8];
    int          npkt;
    int          rx_edges;

    vec_a[0]  = '{1'b1, 1'b0, 16'd0, 16'd0, 1'b0};
    vec_a[1]  = '{1'b1, 1'b1, 16'd0, 16'd0, 1'b0};
    vec_a[2]  = '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0};
    vec_a[3]  = '{1'b1, 1'b1, 16'd1, 16'd1, 1'b0};
    vec_a[4]  = '{1'b0, 1'b1, 16'd1, 16'd1, 1'b0};
    vec_a[5]  = '{1'b0, 1'b1, 16'd1, 16'd1, 1'b0};
    vec_a[6]  = '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0};
    vec_a[7]  = '{1'b1, 1'b1, 16'd2, 16'd2, 1'b0};
    vec_a[8]  = '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0};
    vec_a[9]  = '{1'b1, 1'b1, 16'd3, 16'd3, 1'b0};
    vec_a[10] = '{1'b1, 1'b0, 16'd0, 16'd4, 1'b1};
    vec_a[11] = '{1'b1, 1'b0, 16'd0, 16'd4, 1'b1};

    // ---------------- reset values (instance A) ----------------
    repeat (3) step();
    check_output("rst_data",   if_a.o_data, '0);
    check_output("rst_valid",  if_a.o_data_valid, 1'b0);
    check_output("rst_rxrdy",  if_a.o_data_ready, 1'b0);
    check_output("rst_sent",   sent_a, 16'd0);
    check_output("rst_rcvd",   rcvd_a, 16'd0);
    check_output("rst_txdone", txd_a, 1'b0);
    check_output("rst_err",    err_a, 1'b0);
    rst_a = 1'b0;

    // ---------------- neighbour pattern table ----------------
    for (int i = 0; i < 12; i++) begin
      if_a.i_data_ready = vec_a[i].ready;
      step();
      check_output($sformatf("a_valid[%0d]", i), if_a.o_data_valid, vec_a[i].valid);
      check_output($sformatf("a_sent[%0d]", i), sent_a, vec_a[i].sent);
      check_output($sformatf("a_txdone[%0d]", i), txd_a, vec_a[i].done);
      check_output($sformatf("a_rxrdy[%0d]", i), if_a.o_data_ready, 1'b1);
      if (vec_a[i].valid)
        check_output($sformatf("a_data[%0d]", i), if_a.o_data, mk_pkt(3'd0, 3'd7, vec_a[i].seq));
    end

    // ---------------- RX counting and sticky error ----------------
    if_a.i_data_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if_a.i_data = mk_pkt(3'd7, 3'(k), 16'(k));
      step();
      check_output($sformatf("rx_cnt[%0d]", k), rcvd_a, 16'(k + 1));
      check_output($sformatf("rx_err[%0d]", k), err_a, 1'b0);
    end
    if_a.i_data = mk_pkt(3'd6, 3'd0, 16'd0);
    step();
    check_output("rx_cnt_bad", rcvd_a, 16'd6);
    check_output("rx_err_bad", err_a, 1'b1);
    if_a.i_data_valid = 1'b0;
    if_a.i_data = mk_pkt(3'd7, 3'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("rx_err_sticky", err_a, 1'b1);
      check_output("rx_cnt_hold", rcvd_a, 16'd6);
    end
    rst_a = 1'b1;
    step();
    check_output("rx_err_cleared", err_a, 1'b0);
    check_output("rx_cnt_cleared", rcvd_a, 16'd0);

    // ---------------- random pattern against LFSR model ----------------
    for (int d = 0; d < 8; d++) hist[d] = 0;
    m_lfsr   = 16'h0004;
    npkt     = 0;
    rx_edges = 0;
    if_b.i_data_ready = 1'b1;
    if_b.i_data_valid = 1'b1;
    if_b.i_data       = mk_pkt(3'd3, 3'd1, 16'd0);
    rst_b = 1'b0;
    for (int cyc = 0; cyc < 2400 && npkt < 1000; cyc++) begin
      step();
      rx_edges++;
      if (if_b.o_data_valid) begin
        exp_dest = m_lfsr[2:0];
        if (exp_dest == 3'd3) exp_dest = 3'd4;
        got_dest = if_b.o_data[PKT_W-1 -: 3];
        hist[got_dest]++;
        check_output($sformatf("b_pkt[%0d]", npkt), if_b.o_data, mk_pkt(exp_dest, 3'd3, 16'(npkt)));
        m_lfsr = lfsr_next(m_lfsr);
        npkt++;
      end
    end
    check_output("b_pkt_count", 64'(npkt), 64'd1000);
    step();
    rx_edges++;
    if_b.i_data_valid = 1'b0;
    check_output("b_sent", sent_b, 16'd1000);
    check_output("b_txdone", txd_b, 1'b1);
    check_output("b_rcvd", rcvd_b, 16'(rx_edges));
    check_output("b_err", err_b, 1'b0);
    check_output("b_hist_self", 64'(hist[3]), 64'd0);
    for (int d = 0; d < 8; d++)
      if (d != 3) check_output($sformatf("b_hist_seen[%0d]", d), 64'(hist[d] != 0), 64'd1);

    // ---------------- backpressure, gap, i_done, mid-packet reset ----------------
    rst_c = 1'b0;
    step();
    check_output("c_load_valid", if_c.o_data_valid, 1'b0);
    step();
    check_output("c_first_valid", if_c.o_data_valid, 1'b1);
    check_output("c_first_data", if_c.o_data, mk_pkt(3'd2, 3'd5, 16'd0));
    for (int k = 0; k < 10; k++) begin
      step();
      check_output("c_bp_valid", if_c.o_data_valid, 1'b1);
      check_output("c_bp_data", if_c.o_data, mk_pkt(3'd2, 3'd5, 16'd0));
    end
    check_output("c_bp_sent", sent_c, 16'd0);
    if_c.i_data_ready = 1'b1;
    step();
    if_c.i_data_ready = 1'b0;
    check_output("c_acc_valid", if_c.o_data_valid, 1'b0);
    check_output("c_acc_sent", sent_c, 16'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output($sformatf("c_gap_idle[%0d]", k), if_c.o_data_valid, 1'b0);
    end
    step();
    check_output("c_gap_end_valid", if_c.o_data_valid, 1'b1);
    check_output("c_seq1_data", if_c.o_data, mk_pkt(3'd2, 3'd5, 16'd1));

    if_c.i_data_ready = 1'b1;
    step();
    if_c.i_data_ready = 1'b0;
    check_output("c_acc2_sent", sent_c, 16'd2);
    done_c = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_output("c_done_gap_valid", if_c.o_data_valid, 1'b0);
    end
    check_output("c_done_gap_sent", sent_c, 16'd2);
    check_output("c_done_gap_txdone", txd_c, 1'b0);
    done_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("c_resume_idle", if_c.o_data_valid, 1'b0);
    end
    step();
    check_output("c_resume_valid", if_c.o_data_valid, 1'b1);
    check_output("c_seq2_data", if_c.o_data, mk_pkt(3'd2, 3'd5, 16'd2));

    rst_c = 1'b1;
    step();
    check_output("c_rst_valid", if_c.o_data_valid, 1'b0);
    check_output("c_rst_sent", sent_c, 16'd0);
    check_output("c_rst_data", if_c.o_data, '0);
    rst_c = 1'b0;
    step();
    check_output("c_rst_load_valid", if_c.o_data_valid, 1'b0);
    step();
    check_output("c_rst_valid2", if_c.o_data_valid, 1'b1);
    check_output("c_rst_seq0", if_c.o_data, mk_pkt(3'd2, 3'd5, 16'd0));

    done_c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("c_send_done_hold", if_c.o_data_valid, 1'b1);
    end
    if_c.i_data_ready = 1'b1;
    step();
    check_output("c_send_done_acc", sent_c, 16'd1);
    check_output("c_send_done_valid", if_c.o_data_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("c_stop_valid", if_c.o_data_valid, 1'b0);
      check_output("c_stop_txdone", txd_c, 1'b0);
    end
    done_c = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("c_final_valid", if_c.o_data_valid, 1'b0);
    end
    check_output("c_final_sent", sent_c, 16'd1);
    check_output("c_final_txdone", txd_c, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
